// File: rtl/jtdd2_subctl.sv
// Bus-ownership sequencer between the DD2 main CPU and the sub Z80: halts the sub via
// BUSRQ/BUSAK around shared-RAM accesses, and handles the main<->sub NMI/IRQ signalling.
module jtdd2_subctl #(
  parameter int TOUT = 4096,
  parameter bit AUTO = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cen,
  input  logic       ctl_we,
  input  logic [7:0] ctl_din,
  output logic [7:0] status,
  input  logic       com_cs,
  output logic       main_wait,
  output logic       com_grant,
  output logic       mcu_halt,
  input  logic       mcu_ban,
  output logic       mcu_nmi_set,
  input  logic       mcu_irqmain,
  output logic       main_irq,
  input  logic       main_irq_ack
);

  localparam int              CW       = $clog2(TOUT + 1);
  localparam logic [CW-1:0]   TOUT_CNT = CW'(TOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic            halt_reg;
  logic            tout_flag, tout_set, tout_clr;
  logic            req;
  logic            irq_prev, irq_rise;
  logic            unused_ctl;

  // Control bits 1 and 7:4 have no function in this block.
  assign unused_ctl = ^{ctl_din[7:4], ctl_din[1]};

  // Once a timeout has been flagged, only an explicit halt request can start the FSM.
  assign req       = halt_reg | (AUTO & com_cs & ~tout_flag);
  assign tout_clr  = ctl_we & ctl_din[3];
  assign irq_rise  = mcu_irqmain & ~irq_prev;

  assign main_wait = com_cs & ~com_grant & ~tout_flag;
  assign status    = {5'b0, tout_flag, main_irq, com_grant};

  // Saturating tick count; it stops at TOUT instead of wrapping.
  assign cnt_inc = (cen && cnt != TOUT_CNT) ? cnt + CW'(1) : cnt;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    tout_set  = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = REQ;
      end
      REQ: begin
        cnt_nxt = cnt_inc;
        if (!mcu_ban) begin
          state_nxt = GRANT;
          cnt_nxt   = '0;
        end else if (cnt_inc == TOUT_CNT) begin
          tout_set  = 1'b1;
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else if (!req) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // A BUSAK that goes away while we own the bus means ownership was lost: re-request.
        if (!req)        state_nxt = RELEASE;
        else if (mcu_ban) state_nxt = REQ;
      end
      RELEASE: begin
        if (mcu_ban) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      mcu_halt  <= 1'b1;
      com_grant <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // Outputs decoded from the next state so they change on the same edge as the state.
      mcu_halt  <= ~(state_nxt == REQ || state_nxt == GRANT);
      com_grant <= (state_nxt == GRANT);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_reg    <= 1'b0;
      tout_flag   <= 1'b0;
      mcu_nmi_set <= 1'b0;
    end else begin
      if (ctl_we) halt_reg <= ctl_din[0];
      tout_flag   <= tout_set | (tout_flag & ~tout_clr);
      mcu_nmi_set <= ctl_we & ctl_din[2];
    end
  end

  // Sub-to-main interrupt: edge-detected set has priority over the acknowledge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_prev <= 1'b0;
      main_irq <= 1'b0;
    end else begin
      irq_prev <= mcu_irqmain;
      main_irq <= irq_rise | (main_irq & ~main_irq_ack);
    end
  end

endmodule

// File: tb/tb_jtdd2_subctl.sv
// Self-checking bench for jtdd2_subctl: directed scenarios followed by randomized traffic,
// all compared against a bus-ownership model kept in the bench.
module tb_jtdd2_subctl;

  localparam int TOUT = 16;

  logic       clk;
  logic       rstn;
  logic       cen;
  logic       ctl_we;
  logic [7:0] ctl_din;
  logic [7:0] status;
  logic       com_cs;
  logic       main_wait;
  logic       com_grant;
  logic       mcu_halt;
  logic       mcu_ban;
  logic       mcu_nmi_set;
  logic       mcu_irqmain;
  logic       main_irq;
  logic       main_irq_ack;

  jtdd2_subctl #(.TOUT(TOUT), .AUTO(1'b1)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cen          (cen),
    .ctl_we       (ctl_we),
    .ctl_din      (ctl_din),
    .status       (status),
    .com_cs       (com_cs),
    .main_wait    (main_wait),
    .com_grant    (com_grant),
    .mcu_halt     (mcu_halt),
    .mcu_ban      (mcu_ban),
    .mcu_nmi_set  (mcu_nmi_set),
    .mcu_irqmain  (mcu_irqmain),
    .main_irq     (main_irq),
    .main_irq_ack (main_irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the sub bus is described by "busrq asserted", "we own it",
  // "waiting for the sub to let go", plus the tick count of the pending request.
  bit m_busrq, m_owned, m_drain;
  bit m_halt, m_tout, m_nmi, m_irq, m_prev;
  int m_ticks;

  task automatic model_reset();
    m_busrq = 0; m_owned = 0; m_drain = 0;
    m_halt  = 0; m_tout  = 0; m_nmi   = 0;
    m_irq   = 0; m_prev  = 0; m_ticks = 0;
  endtask

  task automatic model_edge();
    bit r, tset;
    if (!rstn) begin
      model_reset();
    end else begin
      r    = m_halt | (com_cs & !m_tout);
      tset = 0;
      if (!m_busrq) begin
        m_ticks = 0;
        if (m_drain) begin
          if (mcu_ban) m_drain = 0;
        end else if (r) begin
          m_busrq = 1;
        end
      end else if (!m_owned) begin
        if (cen && m_ticks < TOUT) m_ticks++;
        if (!mcu_ban) begin
          m_owned = 1; m_ticks = 0;
        end else if (m_ticks == TOUT) begin
          tset = 1; m_busrq = 0; m_drain = 1; m_ticks = 0;
        end else if (!r) begin
          m_busrq = 0; m_drain = 1; m_ticks = 0;
        end
      end else begin
        if (!r) begin
          m_busrq = 0; m_owned = 0; m_drain = 1;
        end else if (mcu_ban) begin
          m_owned = 0;
        end
      end
      m_tout = tset | (m_tout & !(ctl_we & ctl_din[3]));
      if (ctl_we) m_halt = ctl_din[0];
      m_nmi  = ctl_we & ctl_din[2];
      m_irq  = (mcu_irqmain & !m_prev) | (m_irq & !main_irq_ack);
      m_prev = mcu_irqmain;
    end
  endtask

  task automatic check_outputs();
    check("mcu_halt",    {7'b0, mcu_halt},    {7'b0, !m_busrq});
    check("com_grant",   {7'b0, com_grant},   {7'b0, m_owned});
    check("mcu_nmi_set", {7'b0, mcu_nmi_set}, {7'b0, m_nmi});
    check("main_irq",    {7'b0, main_irq},    {7'b0, m_irq});
    check("status",      status,              {5'b0, m_tout, m_irq, m_owned});
    check("main_wait",   {7'b0, main_wait},   {7'b0, com_cs & !m_owned & !m_tout});
  endtask

  // One clock: model advances on the edge, outputs compared 1 ns later, return at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic write_ctl(input logic [7:0] d);
    ctl_we  = 1'b1;
    ctl_din = d;
    step();
    ctl_we  = 1'b0;
    ctl_din = 8'h00;
  endtask

  int sub_cnt;

  initial begin
    rstn = 1'b0; cen = 1'b1; ctl_we = 1'b0; ctl_din = 8'h00; com_cs = 1'b0;
    mcu_ban = 1'b1; mcu_irqmain = 1'b0; main_irq_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst status",    status,                8'h00);
    check("rst mcu_halt",  {7'b0, mcu_halt},      8'h01);
    check("rst com_grant", {7'b0, com_grant},     8'h00);
    check("rst nmi",       {7'b0, mcu_nmi_set},   8'h00);
    check("rst main_irq",  {7'b0, main_irq},      8'h00);
    check("rst main_wait", {7'b0, main_wait},     8'h00);
    rstn = 1'b1;

    // Halt through the control register, BUSAK three cycles after the request.
    write_ctl(8'h01);
    check("halt not yet", {7'b0, mcu_halt}, 8'h01);
    step();
    check("halt req", {7'b0, mcu_halt}, 8'h00);
    step(); step();
    mcu_ban = 1'b0;
    step();
    check("grant on ack", {7'b0, com_grant}, 8'h01);
    write_ctl(8'h00);
    step();
    check("release halt", {7'b0, mcu_halt}, 8'h01);
    mcu_ban = 1'b1;
    step();
    check("idle halt", {7'b0, mcu_halt}, 8'h01);
    check("idle grant", {7'b0, com_grant}, 8'h00);

    // AUTO request from a shared-RAM access.
    com_cs = 1'b1;
    #1 check("auto wait0", {7'b0, main_wait}, 8'h01);
    @(negedge clk);
    step();
    check("auto req", {7'b0, mcu_halt}, 8'h00);
    step(); step();
    check("auto wait", {7'b0, main_wait}, 8'h01);
    mcu_ban = 1'b0;
    step();
    check("auto granted wait", {7'b0, main_wait}, 8'h00);
    check("auto granted", {7'b0, com_grant}, 8'h01);
    com_cs = 1'b0;
    step();
    check("auto release", {7'b0, mcu_halt}, 8'h01);
    mcu_ban = 1'b1;
    step();

    // NMI while in GRANT.
    write_ctl(8'h01);
    step();
    mcu_ban = 1'b0;
    step();
    write_ctl(8'h05);
    check("nmi pulse", {7'b0, mcu_nmi_set}, 8'h01);
    check("nmi grant kept", {7'b0, com_grant}, 8'h01);
    step();
    check("nmi single", {7'b0, mcu_nmi_set}, 8'h00);
    check("nmi grant still", {7'b0, com_grant}, 8'h01);
    write_ctl(8'h00);
    step();
    mcu_ban = 1'b1;
    step();

    // Sub interrupt: long level sets once; ack coinciding with a new edge loses.
    mcu_irqmain = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("irq set", {7'b0, main_irq}, 8'h01);
    mcu_irqmain = 1'b0;
    step();
    mcu_irqmain  = 1'b1;
    main_irq_ack = 1'b1;
    step();
    check("irq set wins", {7'b0, main_irq}, 8'h01);
    mcu_irqmain = 1'b0;
    step();
    check("irq acked", {7'b0, main_irq}, 8'h00);
    main_irq_ack = 1'b0;
    step();

    // Timeout: BUSAK never arrives, cen every cycle.
    com_cs = 1'b1;
    for (int i = 0; i < TOUT + 1; i++) step();
    check("tout status", status, 8'h04);
    check("tout halt", {7'b0, mcu_halt}, 8'h01);
    check("tout wait", {7'b0, main_wait}, 8'h00);
    step(); step();
    check("tout no auto", {7'b0, mcu_halt}, 8'h01);
    com_cs = 1'b0;
    write_ctl(8'h08);
    check("tout cleared", status, 8'h00);

    // Asynchronous reset in the middle of GRANT.
    write_ctl(8'h01);
    step();
    mcu_ban = 1'b0;
    step();
    check("pre-reset grant", {7'b0, com_grant}, 8'h01);
    #2 rstn = 1'b0;
    #1;
    check("arst halt",   {7'b0, mcu_halt},    8'h01);
    check("arst grant",  {7'b0, com_grant},   8'h00);
    check("arst status", status,              8'h00);
    check("arst nmi",    {7'b0, mcu_nmi_set}, 8'h00);
    check("arst irq",    {7'b0, main_irq},    8'h00);
    check("arst wait",   {7'b0, main_wait},   8'h00);
    model_reset();
    mcu_ban = 1'b1;
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic with a sub that acknowledges after a random delay.
    sub_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      cen          = ($urandom_range(0, 1) == 1);
      ctl_we       = ($urandom_range(0, 9) == 0);
      ctl_din      = 8'($urandom);
      if ($urandom_range(0, 9) == 0) com_cs = ~com_cs;
      if ($urandom_range(0, 4) == 0) mcu_irqmain = ~mcu_irqmain;
      main_irq_ack = ($urandom_range(0, 9) == 0);
      if (!mcu_halt) begin
        if (mcu_ban) begin
          if (sub_cnt == 0) mcu_ban = 1'b0;
          else sub_cnt--;
        end else if ($urandom_range(0, 63) == 0) begin
          mcu_ban = 1'b1;
        end
      end else begin
        if (!mcu_ban && $urandom_range(0, 2) == 0) mcu_ban = 1'b1;
        sub_cnt = $urandom_range(0, 40);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
